shader_scheduler: RTL and testbench

//  Sequences the shader datapath: generates the per-pixel execute/rotate window, subpixel and

---
 rtl/tiny_shader_pkg.sv | 8 +
 rtl/shader_pos_counter.sv | 40 ++++
 rtl/shader_scheduler.sv | 66 ++++++
 tb/tb_shader_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tiny_shader_pkg.sv
// tiny_shader_pkg: shared shader timing constants and scheduler state type
package tiny_shader_pkg;
    localparam int NUM_INSTR = 10;
    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int CNT_W     = 11;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;
endpackage

// File: rtl/shader_pos_counter.sv
// shader_pos_counter: subpixel and coarse x/y position counters with colour-capture strobe
module shader_pos_counter #(
    parameter int NUM_INSTR = tiny_shader_pkg::NUM_INSTR,
    parameter int SUB_W     = $clog2(NUM_INSTR)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             x_adv,
    input  logic             v_active,
    input  logic             next_vertical_i,
    input  logic             next_frame_i,
    output logic [SUB_W-1:0] x_sub,
    output logic [5:0]       x_pos,
    output logic [5:0]       y_pos,
    output logic             capture_o
);
    import tiny_shader_pkg::*;
    logic [SUB_W-1:0] y_sub;
    logic x_last, y_step, y_last;
    always_comb begin
        x_last = x_sub == SUB_W'(NUM_INSTR - 1);
        y_step = next_vertical_i && v_active;
        y_last = y_sub == SUB_W'(NUM_INSTR - 1);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_sub     <= '0;
            y_sub     <= '0;
            x_pos     <= '0;
            y_pos     <= '0;
            capture_o <= 1'b0;
        end else begin
            x_sub     <= x_adv ? (x_last ? '0 : x_sub + SUB_W'(1)) : x_sub;
            x_pos     <= next_vertical_i ? '0 : x_pos + 6'(x_last);
            y_sub     <= next_frame_i ? '0 : y_step ? (y_last ? '0 : y_sub + SUB_W'(1)) : y_sub;
            y_pos     <= next_frame_i ? '0 : y_pos + 6'(y_step && y_last);
            capture_o <= x_last;
        end
    end
endmodule

// File: rtl/shader_scheduler.sv
// shader_scheduler: pixel execute window, position sequencing and deferred shader-memory load arbitration
module shader_scheduler #(
    parameter int NUM_INSTR   = tiny_shader_pkg::NUM_INSTR,
    parameter int WIDTH       = tiny_shader_pkg::H_ACTIVE,
    parameter int HEIGHT      = tiny_shader_pkg::V_ACTIVE,
    parameter int CNT_W       = tiny_shader_pkg::CNT_W,
    parameter bit VBLANK_ONLY = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic signed [CNT_W-1:0] counter_h_i,
    input  logic signed [CNT_W-1:0] counter_v_i,
    input  logic                    next_vertical_i,
    input  logic                    next_frame_i,
    input  logic                    vblank_i,
    input  logic                    load_req_i,
    input  logic [7:0]              load_instr_i,
    output logic                    load_ack_o,
    output logic                    mem_shift_o,
    output logic                    mem_load_o,
    output logic [7:0]              mem_instr_o,
    output logic                    execute_o,
    output logic [5:0]              x_pos_o,
    output logic [5:0]              y_pos_o,
    output logic                    capture_o
);
    import tiny_shader_pkg::*;
    localparam int SUB_W = $clog2(NUM_INSTR);
    sched_state_t state, state_n;
    logic [SUB_W-1:0] x_sub;
    logic [CNT_W:0] h_lead;
    logic h_active, v_active, win, sub_zero, x_last;
    always_comb begin
        h_lead      = {counter_h_i[CNT_W-1], counter_h_i} + (CNT_W+1)'(NUM_INSTR);
        h_active    = !h_lead[CNT_W] && h_lead[CNT_W-1:0] < CNT_W'(WIDTH);
        v_active    = !counter_v_i[CNT_W-1] && $unsigned(counter_v_i) < CNT_W'(HEIGHT);
        win         = rst_ni && h_active && v_active;
        sub_zero    = x_sub == '0;
        x_last      = x_sub == SUB_W'(NUM_INSTR - 1);
        load_ack_o  = rst_ni && load_req_i && !win && sub_zero && (vblank_i || !VBLANK_ONLY);
        mem_shift_o = win || !sub_zero || load_ack_o;
        mem_load_o  = load_ack_o;
        mem_instr_o = load_instr_i;
        execute_o   = win;
        state_n     = state == IDLE ? (win ? RUN : IDLE)
                    : state == RUN  ? (win ? RUN : sub_zero ? IDLE : DRAIN)
                    : state == DRAIN ? (x_last ? IDLE : DRAIN)
                    : IDLE;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else state <= state_n;
    end
    shader_pos_counter #(.NUM_INSTR(NUM_INSTR), .SUB_W(SUB_W)) u_pos (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .x_adv           (win || !sub_zero),
        .v_active        (v_active),
        .next_vertical_i (next_vertical_i),
        .next_frame_i    (next_frame_i),
        .x_sub           (x_sub),
        .x_pos           (x_pos_o),
        .y_pos           (y_pos_o),
        .capture_o       (capture_o)
    );
endmodule

// File: tb/tb_shader_scheduler.sv
// tb_shader_scheduler: scoreboard bench for shader_scheduler sequencing and load arbitration
module tb_shader_scheduler;
    import tiny_shader_pkg::*;
    typedef struct {int cyc; int val;} ev_t;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic signed [10:0] counter_h, counter_v;
    logic nv, nf, vb, req, req0;
    logic [7:0] instr;
    logic ack, shift, load, exec, cap;
    logic [7:0] minstr;
    logic [5:0] xpos, ypos;
    logic ack0, shift0, load0, exec0, cap0;
    logic [7:0] minstr0;
    logic [5:0] xpos0, ypos0;
    int cyc, errors, checks, exec_cnt, shift_cnt, xp_exp, s0, c;
    ev_t cap_q[$], ack_q[$], ack0_q[$];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    shader_scheduler dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .counter_h_i(counter_h), .counter_v_i(counter_v),
        .next_vertical_i(nv), .next_frame_i(nf), .vblank_i(vb), .load_req_i(req),
        .load_instr_i(instr), .load_ack_o(ack), .mem_shift_o(shift), .mem_load_o(load),
        .mem_instr_o(minstr), .execute_o(exec), .x_pos_o(xpos), .y_pos_o(ypos), .capture_o(cap)
    );

    shader_scheduler #(.VBLANK_ONLY(1'b0)) dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .counter_h_i(counter_h), .counter_v_i(counter_v),
        .next_vertical_i(nv), .next_frame_i(nf), .vblank_i(vb), .load_req_i(req0),
        .load_instr_i(instr), .load_ack_o(ack0), .mem_shift_o(shift0), .mem_load_o(load0),
        .mem_instr_o(minstr0), .execute_o(exec0), .x_pos_o(xpos0), .y_pos_o(ypos0), .capture_o(cap0)
    );

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void expect_ev(int which, int cy, int v);
        ev_t e;
        e.cyc = cy;
        e.val = v;
        if (which == 0) cap_q.push_back(e);
        else if (which == 1) ack_q.push_back(e);
        else ack0_q.push_back(e);
    endfunction

    always @(negedge clk_i) begin
        ev_t e;
        if (rst_ni) begin
            exec_cnt += int'(exec);
            shift_cnt += int'(shift);
            if (cap) begin
                if (cap_q.size() == 0) chk("capture_unexpected", 1, 0);
                else begin
                    e = cap_q.pop_front();
                    chk("capture_cycle", cyc, e.cyc);
                    chk("capture_x_pos", int'(xpos), e.val);
                end
            end
            if (ack) begin
                if (ack_q.size() == 0) chk("ack_unexpected", 1, 0);
                else begin
                    e = ack_q.pop_front();
                    chk("ack_cycle", cyc, e.cyc);
                    chk("ack_instr", int'(minstr), e.val);
                    chk("ack_mem_load", int'(load), 1);
                    chk("ack_mem_shift", int'(shift), 1);
                    chk("ack_in_vblank", int'(vb), 1);
                end
            end
            if (ack0) begin
                if (ack0_q.size() == 0) chk("ack0_unexpected", 1, 0);
                else begin
                    e = ack0_q.pop_front();
                    chk("ack0_cycle", cyc, e.cyc);
                    chk("ack0_instr", int'(minstr0), e.val);
                    chk("ack0_mem_load", int'(load0), 1);
                    chk("ack0_mem_shift", int'(shift0), 1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic blank(int n);
        counter_h = -11'sd100;
        repeat (n) step();
    endtask

    task automatic run_h(int lo, int hi, int nv_at);
        for (int h = lo; h <= hi; h++) begin
            counter_h = 11'(h);
            nv = (h == nv_at);
            if (h >= -NUM_INSTR && h < H_ACTIVE - NUM_INSTR && (h + NUM_INSTR) % NUM_INSTR == NUM_INSTR - 1) begin
                xp_exp = nv ? 0 : (xp_exp + 1) % 64;
                expect_ev(0, cyc + 1, xp_exp);
            end else if (nv) xp_exp = 0;
            step();
        end
        nv = 1'b0;
        counter_h = -11'sd100;
    endtask

    task automatic pulse(logic v_nv, logic v_nf);
        nv = v_nv;
        nf = v_nf;
        step();
        nv = 1'b0;
        nf = 1'b0;
    endtask

    initial begin
        counter_h = -11'sd100; counter_v = '0;
        nv = 0; nf = 0; vb = 0; req = 0; req0 = 0; instr = '0;
        repeat (3) step();
        rst_ni = 1'b1;
        run_h(-10, -6, 1000);
        counter_h = -11'sd5;
        #1 chk("pre_reset_x_sub", int'(dut.x_sub), 5);
        rst_ni = 1'b0;
        #1;
        chk("rst_execute", int'(exec), 0);
        chk("rst_shift", int'(shift), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_load", int'(load), 0);
        chk("rst_instr", int'(minstr), 0);
        chk("rst_capture", int'(cap), 0);
        chk("rst_x_pos", int'(xpos), 0);
        chk("rst_y_pos", int'(ypos), 0);
        chk("rst_state", int'(dut.state), int'(IDLE));
        chk("rst_x_sub", int'(dut.x_sub), 0);
        counter_h = -11'sd100;
        repeat (2) step();
        rst_ni = 1'b1;
        xp_exp = 0;
        exec_cnt = 0;
        run_h(-15, 645, 1000);
        step();
        chk("line_execute_count", exec_cnt, 640);
        chk("line_end_x_pos", int'(xpos), 0);
        run_h(-10, 39, 1000);
        blank(2);
        chk("partial_x_pos", int'(xpos), 5);
        pulse(1'b1, 1'b0);
        xp_exp = 0;
        chk("nv_clears_x_pos", int'(xpos), 0);
        run_h(-10, -1, -1);
        blank(2);
        chk("nv_beats_x_inc", int'(xpos), 0);
        req = 1'b1;
        instr = 8'hA5;
        run_h(-10, 29, 1000);
        blank(3);
        counter_v = 11'sd480;
        vb = 1'b1;
        expect_ev(1, cyc, 8'hA5);
        step();
        req = 1'b0;
        blank(2);
        s0 = shift_cnt;
        for (int i = 0; i < 10; i++) begin
            req = 1'b1;
            instr = 8'(8'h10 + i);
            expect_ev(1, cyc, 8'h10 + i);
            step();
        end
        req = 1'b0;
        blank(3);
        chk("b2b_shift_count", shift_cnt - s0, 10);
        counter_v = '0;
        vb = 1'b0;
        blank(2);
        run_h(-10, -4, 1000);
        req0 = 1'b1;
        instr = 8'h5C;
        c = cyc;
        expect_ev(2, c + 3, 8'h5C);
        xp_exp = (xp_exp + 1) % 64;
        expect_ev(0, c + 3, xp_exp);
        repeat (4) step();
        req0 = 1'b0;
        blank(2);
        pulse(1'b0, 1'b1);
        chk("nf_clears_y_pos", int'(ypos), 0);
        chk("nf_clears_y_sub", int'(dut.u_pos.y_sub), 0);
        repeat (10) pulse(1'b1, 1'b0);
        chk("y_pos_after_10_lines", int'(ypos), 1);
        repeat (9) pulse(1'b1, 1'b0);
        chk("y_sub_at_9", int'(dut.u_pos.y_sub), 9);
        counter_v = 11'sd480;
        pulse(1'b1, 1'b0);
        chk("y_sub_hold_outside", int'(dut.u_pos.y_sub), 9);
        chk("y_pos_hold_outside", int'(ypos), 1);
        counter_v = '0;
        pulse(1'b1, 1'b1);
        chk("nf_beats_y_inc_pos", int'(ypos), 0);
        chk("nf_beats_y_inc_sub", int'(dut.u_pos.y_sub), 0);
        blank(3);
        chk("capture_queue_drained", cap_q.size(), 0);
        chk("ack_queue_drained", ack_q.size(), 0);
        chk("ack0_queue_drained", ack0_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
